// File: rtl/ps2_mouse_acc.sv
// PS/2 mouse motion accumulator: sums X/Y/wheel deltas between host polls,
// saturates each axis, and hands out a snapshot on a one-cycle read handshake.
module ps2_mouse_acc #(
  parameter int CLIP_W   = 9,
  parameter bit WHEEL_EN = 1,
  parameter bit INVERT_Y = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [24:0]       ps2_mouse,
  input  logic [15:0]       ps2_mouse_ext,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [3:0]        flags,
  output logic [3:0]        buttons,
  output logic [CLIP_W-2:0] x,
  output logic [CLIP_W-2:0] y,
  output logic [7:0]        z,
  output logic              moved
);
  localparam int AW = CLIP_W + 1;
  localparam logic signed [AW-1:0] MAXV = {2'b00, {(CLIP_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {2'b11, {(CLIP_W-1){1'b0}}};

  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;

  logic primed, old_stb, strobe, snap;
  logic signed [AW-1:0] acc_x, acc_y, dx, dy_raw, dy;
  logic signed [AW-1:0] sum_x, sum_y, nx_x, nx_y;
  logic signed [8:0]    acc_z, dz, sum_z, nx_z;
  logic                 x_ov, y_ov, clip_x, clip_y;
  logic                 unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3]};

  // primed keeps the first post-reset edge from seeing a false toggle
  assign strobe = primed & (ps2_mouse[24] ^ old_stb);

  assign dx     = {{(AW-9){ps2_mouse[4]}}, ps2_mouse[4], ps2_mouse[15:8]};
  assign dy_raw = {{(AW-9){ps2_mouse[5]}}, ps2_mouse[5], ps2_mouse[23:16]};
  assign dy     = INVERT_Y ? -dy_raw : dy_raw;
  assign dz     = {ps2_mouse_ext[7], ps2_mouse_ext[7:0]};

  always_comb begin
    state_d = state_q;
    rd_ack  = 1'b0;
    snap    = 1'b0;
    case (state_q)
      IDLE: if (ce && rd_req) begin
        snap    = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        rd_ack  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a packet coinciding with a snapshot lands on a zero base
  always_comb begin
    sum_x  = (snap ? '0 : acc_x) + dx;
    sum_y  = (snap ? '0 : acc_y) + dy;
    sum_z  = (snap ? '0 : acc_z) + dz;
    nx_x   = sum_x;
    nx_y   = sum_y;
    nx_z   = sum_z;
    clip_x = 1'b0;
    clip_y = 1'b0;
    if (sum_x > MAXV)      begin nx_x = MAXV; clip_x = 1'b1; end
    else if (sum_x < MINV) begin nx_x = MINV; clip_x = 1'b1; end
    if (sum_y > MAXV)      begin nx_y = MAXV; clip_y = 1'b1; end
    else if (sum_y < MINV) begin nx_y = MINV; clip_y = 1'b1; end
    if (sum_z > 9'sd127)       nx_z = 9'sd127;
    else if (sum_z < -9'sd128) nx_z = -9'sd128;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      primed  <= 1'b0;
      old_stb <= 1'b0;
      acc_x   <= '0;
      acc_y   <= '0;
      acc_z   <= '0;
      x_ov    <= 1'b0;
      y_ov    <= 1'b0;
      buttons <= '0;
      flags   <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
    end else begin
      state_q <= state_d;
      primed  <= 1'b1;
      old_stb <= ps2_mouse[24];
      if (strobe) begin
        acc_x   <= nx_x;
        acc_y   <= nx_y;
        acc_z   <= WHEEL_EN ? nx_z : 9'sd0;
        buttons <= {|ps2_mouse_ext[15:8], ps2_mouse[2:0]};
      end else if (snap) begin
        acc_x <= '0;
        acc_y <= '0;
        acc_z <= '0;
      end
      x_ov <= (x_ov & ~snap) | (strobe & clip_x);
      y_ov <= (y_ov & ~snap) | (strobe & clip_y);
      if (snap) begin
        x     <= acc_x[CLIP_W-2:0];
        y     <= acc_y[CLIP_W-2:0];
        z     <= acc_z[7:0];
        flags <= {y_ov, x_ov, acc_y[AW-1], acc_x[AW-1]};
      end
    end
  end

  assign moved = (|acc_x) | (|acc_y) | (|acc_z) | x_ov | y_ov;
endmodule

// File: tb/tb_ps2_mouse_acc.sv
// Directed bench for ps2_mouse_acc: a default instance and an INVERT_Y=1,
// WHEEL_EN=0 instance share stimulus so both variants are checked together.
module tb_ps2_mouse_acc;
  logic        clk = 1'b0;
  logic        reset_n, ce, rd_req;
  logic [24:0] ps2_mouse;
  logic [15:0] ps2_mouse_ext;
  logic        rd_ack, moved, rd_ack2, moved2;
  logic [3:0]  flags, buttons, flags2, buttons2;
  logic [7:0]  x, y, z, x2, y2, z2;
  logic        tog;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ps2_mouse_acc u_dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
    .ps2_mouse_ext(ps2_mouse_ext), .rd_req(rd_req), .rd_ack(rd_ack),
    .flags(flags), .buttons(buttons), .x(x), .y(y), .z(z), .moved(moved));

  ps2_mouse_acc #(.CLIP_W(9), .WHEEL_EN(0), .INVERT_Y(1)) u_alt (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
    .ps2_mouse_ext(ps2_mouse_ext), .rd_req(rd_req), .rd_ack(rd_ack2),
    .flags(flags2), .buttons(buttons2), .x(x2), .y(y2), .z(z2), .moved(moved2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [24:0] pkt(input logic t, input logic [8:0] ddx,
                                      input logic [8:0] ddy, input logic [2:0] b);
    return {t, ddy[7:0], ddx[7:0], 2'b00, ddy[8], ddx[8], 1'b0, b};
  endfunction

  task automatic send(input logic [8:0] ddx, input logic [8:0] ddy,
                      input logic [7:0] ddz, input logic [2:0] b, input logic [7:0] eb);
    @(negedge clk);
    tog           = ~tog;
    ps2_mouse     = pkt(tog, ddx, ddy, b);
    ps2_mouse_ext = {eb, ddz};
    @(posedge clk);
  endtask

  // Leaves the bench sampling inside the rd_ack cycle; caller checks outputs,
  // then calls ack_done to confirm the pulse is one cycle wide.
  task automatic start_read;
    int n;
    @(negedge clk);
    ce = 1'b1; rd_req = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!rd_ack && n < 8);
    rd_req = 1'b0; ce = 1'b0;
    chk("rd_ack_seen", rd_ack, 1'b1);
    chk("rd_ack_alt", rd_ack2, 1'b1);
  endtask

  task automatic ack_done;
    @(posedge clk); #1;
    chk("ack_pulse", rd_ack, 1'b0);
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0; ce = 1'b0; rd_req = 1'b0; tog = 1'b1;
    ps2_mouse = pkt(1'b1, 9'd33, 9'd44, 3'b111); ps2_mouse_ext = 16'hFF11;
    #1;
    chk("rst_ack", rd_ack, 0); chk("rst_x", x, 0); chk("rst_y", y, 0);
    chk("rst_z", z, 0); chk("rst_flags", flags, 0); chk("rst_moved", moved, 0);
    chk("rst_buttons", buttons, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_first_strobe_moved", moved, 0);
    chk("no_first_strobe_btn", buttons, 0);

    // rd_req without ce must not be accepted
    @(negedge clk); rd_req = 1'b1; seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= rd_ack; end
    rd_req = 1'b0;
    chk("ce_gates_req", seen, 0);

    start_read;
    chk("idle_x", x, 0); chk("idle_y", y, 0); chk("idle_z", z, 0); chk("idle_flags", flags, 0);
    ack_done;

    send(9'd100, 9'd0, 8'd0, 3'b101, 8'h10);
    send(9'd50, 9'd0, 8'd0, 3'b101, 8'h10);
    #1;
    chk("buttons", buttons, 4'b1101); chk("moved_before", moved, 1);
    start_read;
    chk("sum_x", x, 8'h96); chk("sum_flags", flags, 4'b0000);
    chk("sum_x_alt", x2, 8'h96); chk("moved_after", moved, 0);
    ack_done;

    repeat (3) send(9'd200, 9'd0, 8'd0, 3'b000, 8'h00);
    start_read;
    chk("clip_x", x, 8'hFF); chk("clip_flags", flags, 4'b0100);
    ack_done;
    start_read;
    chk("clear_x", x, 0); chk("clear_flags", flags, 0);
    ack_done;

    repeat (2) send(9'd0, -9'sd200, 8'd0, 3'b000, 8'h00);
    start_read;
    chk("neg_y", y, 8'h00); chk("neg_flags", flags, 4'b1010);
    chk("inv_y", y2, 8'hFF); chk("inv_flags", flags2, 4'b1000);
    ack_done;

    // packet on the accepting edge belongs to the next snapshot
    send(9'd5, 9'd0, 8'd0, 3'b000, 8'h00);
    @(negedge clk);
    ce = 1'b1; rd_req = 1'b1; tog = ~tog;
    ps2_mouse = pkt(tog, 9'd10, 9'd0, 3'b000); ps2_mouse_ext = 16'h0000;
    @(posedge clk); #1;
    rd_req = 1'b0; ce = 1'b0;
    chk("coin_ack", rd_ack, 1); chk("coin_x", x, 8'd5); chk("coin_moved", moved, 1);
    ack_done;
    start_read;
    chk("coin_next_x", x, 8'd10);
    ack_done;

    repeat (2) send(9'd0, 9'd0, 8'd100, 3'b000, 8'h00);
    start_read;
    chk("wheel_z", z, 8'd127); chk("wheel_off_z", z2, 8'd0); chk("wheel_flags", flags, 0);
    ack_done;

    // async reset while rd_ack is high
    send(9'd20, 9'd0, 8'd0, 3'b011, 8'h00);
    @(negedge clk); ce = 1'b1; rd_req = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0; rd_req = 1'b0;
    chk("pre_rst_ack", rd_ack, 1); chk("pre_rst_x", x, 8'd20);
    reset_n = 1'b0; #1;
    chk("mid_rst_ack", rd_ack, 0); chk("mid_rst_x", x, 0);
    chk("mid_rst_buttons", buttons, 0); chk("mid_rst_moved", moved, 0);
    chk("mid_rst_alt_ack", rd_ack2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
